// File: rtl/ristretto_exe_wb_buffer.sv
// ristretto_exe_wb_buffer: two-entry (HEAD + SKID) result buffer between the
// execute and writeback stages. Results leave in the order they were accepted.
// Upstream ready is decoded from the registered state only, so there is no
// combinational path from wb_ready_i to exe_ready_o.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   exe_valid_i / exe_ready_o    execute-side handshake
//   exe_result_i, exe_stat_i,    ALU result, status {zero, overflow, negative},
//   exe_rd_addr_i, exe_rd_we_i   destination register and write enable
//   flush_i                      discard all buffered results
//   wb_valid_o / wb_ready_i      writeback-side handshake on the HEAD entry
//   wb_result_o, wb_stat_o,      HEAD entry fields
//   wb_rd_addr_o, wb_rd_we_o
//   fwd_valid_o, fwd_rd_addr_o,  youngest entry for operand bypass
//   fwd_data_o
//   occupancy_o                  number of valid entries (0..2)
module ristretto_exe_wb_buffer #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned RegAddrWidth = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    exe_valid_i,
  output logic                    exe_ready_o,
  input  logic [DataWidth-1:0]    exe_result_i,
  input  logic [2:0]              exe_stat_i,
  input  logic [RegAddrWidth-1:0] exe_rd_addr_i,
  input  logic                    exe_rd_we_i,
  input  logic                    flush_i,
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output logic [DataWidth-1:0]    wb_result_o,
  output logic [2:0]              wb_stat_o,
  output logic [RegAddrWidth-1:0] wb_rd_addr_o,
  output logic                    wb_rd_we_o,
  output logic                    fwd_valid_o,
  output logic [RegAddrWidth-1:0] fwd_rd_addr_o,
  output logic [DataWidth-1:0]    fwd_data_o,
  output logic [1:0]              occupancy_o
);

  localparam int unsigned StatWidth = 3;

  typedef struct packed {
    logic [DataWidth-1:0]    result;
    logic [StatWidth-1:0]    stat;
    logic [RegAddrWidth-1:0] rd_addr;
    logic                    rd_we;
  } entry_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    Empty = 2'd0,
    One   = 2'd1,
    Two   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    HeadHold = 2'd0,
    HeadIn   = 2'd1,
    HeadSkid = 2'd2
  } head_src_e;

  state_e    state_q, state_d;
  head_src_e head_src;
  logic      skid_load;
  entry_t    head_q, skid_q, in_entry, fwd_sel;
  logic      accept, drain;

  // Incoming entry; writes to x0 are suppressed at capture.
  always_comb begin
    in_entry.result  = exe_result_i;
    in_entry.stat    = exe_stat_i;
    in_entry.rd_addr = exe_rd_addr_i;
    in_entry.rd_we   = exe_rd_we_i & (exe_rd_addr_i != '0);
  end

  // Handshakes are derived from registered state; flush blocks both.
  assign accept = exe_valid_i & (state_q != Two) & ~flush_i;
  assign drain  = (state_q != Empty) & wb_ready_i & ~flush_i;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= Empty;
    else       state_q <= state_d;
  end

  // Next-state and datapath steering.
  always_comb begin
    state_d   = state_q;
    head_src  = HeadHold;
    skid_load = 1'b0;
    if (flush_i) begin
      state_d = Empty;
    end else begin
      unique case (state_q)
        Empty: begin
          if (accept) begin
            state_d  = One;
            head_src = HeadIn;
          end
        end
        One: begin
          if (accept && drain) begin
            head_src = HeadIn;
          end else if (accept) begin
            state_d   = Two;
            skid_load = 1'b1;
          end else if (drain) begin
            state_d = Empty;
          end
        end
        Two: begin
          if (drain) begin
            state_d  = One;
            head_src = HeadSkid;
          end
        end
        default: state_d = Empty;
      endcase
    end
  end

  // Entry storage; contents persist after drain/flush so wb_* hold last values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      unique case (head_src)
        HeadIn:   head_q <= in_entry;
        HeadSkid: head_q <= skid_q;
        default:  head_q <= head_q;
      endcase
      if (skid_load) skid_q <= in_entry;
    end
  end

  // Output decode from registered state and storage.
  always_comb begin
    exe_ready_o   = (state_q != Two);
    wb_valid_o    = (state_q != Empty);
    occupancy_o   = state_q;
    wb_result_o   = head_q.result;
    wb_stat_o     = head_q.stat;
    wb_rd_addr_o  = head_q.rd_addr;
    wb_rd_we_o    = (state_q != Empty) & head_q.rd_we;
    fwd_sel       = (state_q == Two) ? skid_q : head_q;
    fwd_valid_o   = (state_q != Empty) & fwd_sel.rd_we;
    fwd_rd_addr_o = fwd_sel.rd_addr;
    fwd_data_o    = fwd_sel.result;
  end

endmodule

// File: tb/tb_ristretto_exe_wb_buffer.sv
// Scoreboard bench for ristretto_exe_wb_buffer: the driver pushes the expected
// writeback entry for every result it knows will be accepted, and a monitor on
// the falling edge pops and compares whenever a drain handshake is presented.
module tb_ristretto_exe_wb_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_valid, exe_ready;
  logic [31:0] exe_result;
  logic [2:0]  exe_stat;
  logic [4:0]  exe_rd_addr;
  logic        exe_rd_we;
  logic        flush;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_result;
  logic [2:0]  wb_stat;
  logic [4:0]  wb_rd_addr;
  logic        wb_rd_we;
  logic        fwd_valid;
  logic [4:0]  fwd_rd_addr;
  logic [31:0] fwd_data;
  logic [1:0]  occupancy;

  typedef struct packed {
    logic [31:0] result;
    logic [2:0]  stat;
    logic [4:0]  rd_addr;
    logic        rd_we;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  ristretto_exe_wb_buffer #(.DataWidth(32), .RegAddrWidth(5)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .exe_valid_i  (exe_valid),
    .exe_ready_o  (exe_ready),
    .exe_result_i (exe_result),
    .exe_stat_i   (exe_stat),
    .exe_rd_addr_i(exe_rd_addr),
    .exe_rd_we_i  (exe_rd_we),
    .flush_i      (flush),
    .wb_valid_o   (wb_valid),
    .wb_ready_i   (wb_ready),
    .wb_result_o  (wb_result),
    .wb_stat_o    (wb_stat),
    .wb_rd_addr_o (wb_rd_addr),
    .wb_rd_we_o   (wb_rd_we),
    .fwd_valid_o  (fwd_valid),
    .fwd_rd_addr_o(fwd_rd_addr),
    .fwd_data_o   (fwd_data),
    .occupancy_o  (occupancy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one result for a single cycle; push the expected entry when the
  // caller knows it will be accepted.
  task automatic send(input logic [31:0] d, input logic [4:0] rd, input logic we,
                      input logic [2:0] st, input bit expect_accept);
    exp_t e;
    exe_valid   = 1'b1;
    exe_result  = d;
    exe_rd_addr = rd;
    exe_rd_we   = we;
    exe_stat    = st;
    if (expect_accept) begin
      e.result  = d;
      e.stat    = st;
      e.rd_addr = rd;
      e.rd_we   = we & (rd != 5'd0);
      exp_q.push_back(e);
    end
    cyc();
    exe_valid = 1'b0;
  endtask

  // Monitor: compare the head entry on every drain handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!wb_valid) chk("wb_rd_we_idle", 32'(wb_rd_we), 32'd0);
        if (wb_valid && wb_ready && !flush) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_drain: got result 0x%08h expected none", wb_result);
          end else begin
            e = exp_q.pop_front();
            chk("drain_result", wb_result, e.result);
            chk("drain_stat", 32'(wb_stat), 32'(e.stat));
            chk("drain_rd_addr", 32'(wb_rd_addr), 32'(e.rd_addr));
            chk("drain_rd_we", 32'(wb_rd_we), 32'(e.rd_we));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; exe_valid = 1'b0; exe_result = '0; exe_stat = '0;
    exe_rd_addr = '0; exe_rd_we = 1'b0; flush = 1'b0; wb_ready = 1'b0;
    exe_valid = 1'b1;
    cyc(); cyc();
    // Reset state (exe_valid high during reset must not be captured).
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_rd_we", 32'(wb_rd_we), 32'd0);
    chk("rst_wb_result", wb_result, 32'd0);
    chk("rst_wb_stat", 32'(wb_stat), 32'd0);
    chk("rst_wb_rd_addr", 32'(wb_rd_addr), 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_fwd_rd_addr", 32'(fwd_rd_addr), 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_exe_ready", 32'(exe_ready), 32'd1);
    exe_valid = 1'b0;
    rst = 1'b0;
    cyc();
    chk("post_rst_occupancy", 32'(occupancy), 32'd0);

    // Pass-through with one-cycle latency.
    wb_ready = 1'b1;
    send(32'h0000_00AA, 5'd3, 1'b1, 3'b010, 1'b1);
    chk("pt_wb_valid", 32'(wb_valid), 32'd1);
    chk("pt_wb_result", wb_result, 32'h0000_00AA);
    chk("pt_wb_rd_we", 32'(wb_rd_we), 32'd1);
    chk("pt_occupancy", 32'(occupancy), 32'd1);
    chk("pt_fwd_valid", 32'(fwd_valid), 32'd1);
    cyc();
    chk("pt_empty_occ", 32'(occupancy), 32'd0);
    chk("pt_hold_result", wb_result, 32'h0000_00AA);
    chk("pt_hold_rd_we", 32'(wb_rd_we), 32'd0);

    // Back-pressure fills both entries; a third result is refused.
    wb_ready = 1'b0;
    send(32'h11, 5'd1, 1'b1, 3'b001, 1'b1);
    chk("bp_one_ready", 32'(exe_ready), 32'd1);
    send(32'h22, 5'd2, 1'b1, 3'b100, 1'b1);
    chk("bp_occupancy", 32'(occupancy), 32'd2);
    chk("bp_exe_ready", 32'(exe_ready), 32'd0);
    chk("bp_wb_result", wb_result, 32'h11);
    chk("bp_fwd_data", fwd_data, 32'h22);
    chk("bp_fwd_rd_addr", 32'(fwd_rd_addr), 32'd2);
    chk("bp_fwd_valid", 32'(fwd_valid), 32'd1);
    send(32'h99, 5'd9, 1'b1, 3'b000, 1'b0);
    chk("bp_hold_occ", 32'(occupancy), 32'd2);
    chk("bp_hold_result", wb_result, 32'h11);
    wb_ready = 1'b1;
    cyc();
    chk("bp_drain1_occ", 32'(occupancy), 32'd1);
    chk("bp_drain1_result", wb_result, 32'h22);
    cyc();
    chk("bp_drain2_occ", 32'(occupancy), 32'd0);

    // Simultaneous accept and drain in ONE.
    wb_ready = 1'b0;
    send(32'h33, 5'd4, 1'b1, 3'b000, 1'b1);
    wb_ready = 1'b1;
    send(32'h44, 5'd5, 1'b1, 3'b001, 1'b1);
    chk("sim_occupancy", 32'(occupancy), 32'd1);
    chk("sim_wb_result", wb_result, 32'h44);
    chk("sim_fwd_rd_addr", 32'(fwd_rd_addr), 32'd5);
    cyc();
    chk("sim_empty", 32'(occupancy), 32'd0);

    // Writes to x0 are suppressed.
    wb_ready = 1'b0;
    send(32'hFFFF_FFFF, 5'd0, 1'b1, 3'b101, 1'b1);
    chk("x0_wb_valid", 32'(wb_valid), 32'd1);
    chk("x0_wb_rd_we", 32'(wb_rd_we), 32'd0);
    chk("x0_fwd_valid", 32'(fwd_valid), 32'd0);
    wb_ready = 1'b1;
    cyc();
    chk("x0_empty", 32'(occupancy), 32'd0);

    // Flush in TWO with a result presented: everything discarded.
    wb_ready = 1'b0;
    send(32'h55, 5'd6, 1'b1, 3'b000, 1'b1);
    send(32'h66, 5'd7, 1'b1, 3'b000, 1'b1);
    chk("fl_pre_occ", 32'(occupancy), 32'd2);
    flush = 1'b1;
    wb_ready = 1'b1;
    send(32'h77, 5'd8, 1'b1, 3'b000, 1'b0);
    flush = 1'b0;
    exp_q.delete();
    chk("fl_occupancy", 32'(occupancy), 32'd0);
    chk("fl_wb_valid", 32'(wb_valid), 32'd0);
    chk("fl_exe_ready", 32'(exe_ready), 32'd1);
    chk("fl_fwd_valid", 32'(fwd_valid), 32'd0);
    cyc();
    chk("fl_not_captured", 32'(occupancy), 32'd0);
    send(32'h88, 5'd10, 1'b1, 3'b011, 1'b1);
    chk("fl_resume_result", wb_result, 32'h88);
    cyc();

    // Asynchronous reset between edges while TWO.
    wb_ready = 1'b0;
    send(32'h99, 5'd11, 1'b1, 3'b000, 1'b1);
    send(32'hAB, 5'd12, 1'b1, 3'b000, 1'b1);
    chk("ar_pre_occ", 32'(occupancy), 32'd2);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("ar_wb_valid", 32'(wb_valid), 32'd0);
    chk("ar_occupancy", 32'(occupancy), 32'd0);
    chk("ar_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("ar_exe_ready", 32'(exe_ready), 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    cyc();
    chk("ar_after_occ", 32'(occupancy), 32'd0);

    // Every expected entry must have been drained.
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ristretto_exe_wb_buffer.md
RISTRETTO_EXE_WB_BUFFER -- requirements
Module: ristretto_exe_wb_buffer

Interface
REQ-001 The block SHALL have parameter DataWidth, default 32, meaning the width of the result and forwarding data.
REQ-002 The block SHALL have parameter RegAddrWidth, default 5, meaning the width of the register-file address.
REQ-003 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 exe_valid_i  in  1  execute stage presents a completed ALU result.
REQ-006 exe_ready_o  out  1  block can accept a result this cycle.
REQ-007 exe_result_i  in  DataWidth  ALU result.
REQ-008 exe_stat_i  in  3  ALU status {zero, overflow, negative}.
REQ-009 exe_rd_addr_i  in  RegAddrWidth  destination register.
REQ-010 exe_rd_we_i  in  1  destination write enable.
REQ-011 flush_i  in  1  discard all buffered results.
REQ-012 wb_valid_o  out  1  head entry valid towards writeback.
REQ-013 wb_ready_i  in  1  writeback consumes the head entry.
REQ-014 wb_result_o / wb_stat_o / wb_rd_addr_o / wb_rd_we_o  out  DataWidth / 3 / RegAddrWidth / 1  head entry fields.
REQ-015 fwd_valid_o  out  1  youngest buffered entry writes a register.
REQ-016 fwd_rd_addr_o / fwd_data_o  out  RegAddrWidth / DataWidth  youngest entry address and data for operand bypass.
REQ-017 occupancy_o  out  2  number of valid entries (0..2).

Function
REQ-018 Storage SHALL be two entries: HEAD (drives wb_*) and SKID; state EMPTY (0), ONE (HEAD valid), TWO (HEAD and SKID valid).
REQ-019 exe_ready_o SHALL be 1 in EMPTY and ONE, 0 in TWO, decoded from registered state only (no combinational path from wb_ready_i).
REQ-020 Accept SHALL occur when exe_valid_i & exe_ready_o & ~flush_i; drain SHALL occur when wb_valid_o & wb_ready_i & ~flush_i.
REQ-021 Latency SHALL be one cycle: a result accepted at edge N appears on wb_* with wb_valid_o=1 after edge N.
REQ-022 EMPTY: accept -> ONE, data to HEAD.
REQ-023 ONE: accept only -> TWO, data to SKID; drain only -> EMPTY; accept and drain together -> ONE, new data to HEAD.
REQ-024 TWO: drain -> ONE, SKID moves to HEAD; no drain -> TWO, outputs held stable.
REQ-025 Results SHALL leave in acceptance order; no entry SHALL be dropped or duplicated.
REQ-026 At capture, rd_we SHALL be stored as exe_rd_we_i & (exe_rd_addr_i != 0); writes to x0 are suppressed.
REQ-027 wb_result_o, wb_stat_o, wb_rd_addr_o SHALL hold their last values while wb_valid_o=0; wb_rd_we_o SHALL be 0 whenever wb_valid_o=0.
REQ-028 Forwarding SHALL select SKID when valid, else HEAD; fwd_valid_o = selected entry valid & stored rd_we.
REQ-029 flush_i SHALL take priority over accept and drain: at the next edge state -> EMPTY and the cycle's input is discarded.
REQ-030 occupancy_o SHALL equal 0/1/2 for EMPTY/ONE/TWO.

Reset
REQ-031 While rst_i=1, state SHALL be EMPTY immediately (asynchronous), independent of clk_i.
REQ-032 Reset values: wb_valid_o=0, wb_rd_we_o=0, wb_result_o=0, wb_stat_o=0, wb_rd_addr_o=0, fwd_valid_o=0, fwd_rd_addr_o=0, fwd_data_o=0, occupancy_o=0, exe_ready_o=1.
REQ-033 No accept SHALL occur in any cycle where rst_i=1; reset asserted mid-operation SHALL discard all entries.

Verification
REQ-034 Pass-through: wb_ready_i=1, accept result 0x0000_00AA rd=3 we=1 -> next cycle wb_valid_o=1, wb_result_o=0x0000_00AA, wb_rd_we_o=1, occupancy_o=1.
REQ-035 Back-pressure: wb_ready_i=0, send 0x11 then 0x22 -> occupancy_o=2, exe_ready_o=0, wb_result_o=0x11, fwd_data_o=0x22; raise wb_ready_i -> 0x11 then 0x22 drained in order.
REQ-036 Simultaneous accept/drain in ONE with 0x33 head, input 0x44 -> occupancy_o stays 1, wb_result_o=0x44 next cycle.
REQ-037 x0 suppression: accept rd=0 we=1 value 0xFFFF_FFFF -> wb_rd_we_o=0, fwd_valid_o=0, wb_valid_o=1.
REQ-038 Flush in TWO with exe_valid_i=1 -> next cycle occupancy_o=0, wb_valid_o=0, input not captured.
REQ-039 Asynchronous reset between clock edges while TWO -> wb_valid_o=0, occupancy_o=0 without waiting for clk_i.
